// File: rtl/mv_cmd_sequencer.sv
// Command front-end for the matrix-vector multiplier: buffers host commands
// and turns each one into toggle strobes plus operand data on an 8-bit bus.
module mv_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int NUM_ROWS    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_vec,
  output logic [7:0] vector_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] row_idx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CMP   = 2'b01;
  localparam logic [1:0] OP_WR    = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CMP_HOLD, S_WR_HOLD, S_DONE} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          cmd_ready_q;
  logic          push, pop, fifo_empty;
  logic [1:0]    head_op;
  logic [5:0]    head_vec;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_last;
  logic [1:0]    op_q;
  logic [5:0]    vec_q;
  logic          cmp_tgl_q, wr_tgl_q;
  logic          cmp_flip, wr_flip;
  logic [2:0]    row_idx_q;
  logic          done_q, busy_q;

  assign push       = cmd_valid && cmd_ready_q;
  assign fifo_empty = (count_q == '0);
  assign head_op    = mem_q[rd_ptr_q][7:6];
  assign head_vec   = mem_q[rd_ptr_q][5:0];
  assign hold_last  = (hold_cnt_q == HW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_vec};
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Ready is derived from the post-edge count, so a full FIFO refuses a push
  // even in a cycle where the FSM pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            OP_NOP:  state_d = S_DONE;
            OP_WR:   state_d = S_WR_HOLD;
            default: state_d = S_CMP_HOLD;
          endcase
        end
      end
      S_CMP_HOLD: if (hold_last) state_d = (op_q == OP_LOAD) ? S_WR_HOLD : S_DONE;
      S_WR_HOLD:  if (hold_last) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = (state_q == S_IDLE) && !fifo_empty;
    cmp_flip   = pop && (head_op == OP_CMP || head_op == OP_LOAD);
    wr_flip    = (pop && head_op == OP_WR) ||
                 (state_q == S_CMP_HOLD && hold_last && op_q == OP_LOAD);
    hold_cnt_d = '0;
    if ((state_q == S_CMP_HOLD || state_q == S_WR_HOLD) && !hold_last)
      hold_cnt_d = hold_cnt_q + HW'(1);
  end

  // done is registered off the DONE state, so it lands one edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      op_q       <= OP_NOP;
      vec_q      <= '0;
      cmp_tgl_q  <= 1'b0;
      wr_tgl_q   <= 1'b0;
      row_idx_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      if (pop)      op_q  <= head_op;
      if (cmp_flip) vec_q <= head_vec;
      cmp_tgl_q <= cmp_tgl_q ^ cmp_flip;
      wr_tgl_q  <= wr_tgl_q ^ wr_flip;
      if (wr_flip)
        row_idx_q <= (row_idx_q == 3'(NUM_ROWS - 1)) ? 3'd0 : row_idx_q + 3'd1;
      done_q <= (state_q == S_DONE);
      busy_q <= (state_q != S_IDLE) || !fifo_empty;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign vector_out = {vec_q, wr_tgl_q, cmp_tgl_q};
  assign busy       = busy_q;
  assign done       = done_q;
  assign row_idx    = row_idx_q;

endmodule

// File: tb/tb_mv_cmd_sequencer.sv
// Bench for mv_cmd_sequencer: records a randomized command run, then checks
// every cycle against a schedule computed from the command timing rules.
module tb_mv_cmd_sequencer;

  localparam int H     = 3;
  localparam int DEPTH = 4;
  localparam int NR    = 6;
  localparam int NCMD  = 60;
  localparam int MAXC  = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_vec = 6'd0;
  logic       cmd_ready;
  logic [7:0] vector_out;
  logic       busy;
  logic       done;
  logic [2:0] row_idx;

  mv_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(H), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_vec(cmd_vec), .vector_out(vector_out),
    .busy(busy), .done(done), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] c_op  [NCMD];
  logic [5:0] c_vec [NCMD];
  int         push_t [NCMD];
  int         pop_t  [NCMD];
  int         done_t [NCMD];
  logic [7:0] o_vec  [MAXC];
  logic [2:0] o_row  [MAXC];
  logic       o_done [MAXC];
  logic       o_busy [MAXC];
  logic       o_rdy  [MAXC];

  task automatic check(input string tag, input int t, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
    end
  endtask

  task automatic sample(input int t);
    o_vec[t]  = vector_out;
    o_row[t]  = row_idx;
    o_done[t] = done;
    o_busy[t] = busy;
    o_rdy[t]  = cmd_ready;
  endtask

  initial begin
    int cyc, i, tail, last, prev, lat, wr_time;
    int occ, occ_p, cmp_n, wr_n;
    logic [5:0] vec_e;
    logic done_e, busy_e, nonidle_p, will_push, burst;

    // Directed prefix, then random commands.
    for (int k = 0; k < NCMD; k++) begin
      push_t[k] = MAXC * 10;
      if (k == 0)      begin c_op[k] = 2'b01; c_vec[k] = 6'b101101; end
      else if (k <= 7) begin c_op[k] = 2'b10; c_vec[k] = 6'($urandom); end
      else if (k == 8) begin c_op[k] = 2'b11; c_vec[k] = 6'h3F; end
      else if (k == 9) begin c_op[k] = 2'b00; c_vec[k] = 6'($urandom); end
      else             begin c_op[k] = 2'($urandom_range(0, 3)); c_vec[k] = 6'($urandom); end
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    sample(0);
    check("reset_vec", 0, vector_out, 8'h00);
    check("reset_ready", 0, 8'(cmd_ready), 8'd1);
    check("reset_busy", 0, 8'(busy), 8'd0);
    check("reset_done", 0, 8'(done), 8'd0);
    check("reset_row", 0, 8'(row_idx), 8'd0);

    i = 0;
    tail = 0;
    while (cyc < MAXC - 1 && tail < 60) begin
      if (i < NCMD) begin
        burst     = (i >= 10 && i < 15);
        cmd_valid = burst || ($urandom_range(0, 3) != 0);
        cmd_op    = c_op[i];
        cmd_vec   = c_vec[i];
      end else begin
        cmd_valid = 1'b0;
        tail++;
      end
      will_push = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (will_push) begin
        push_t[i] = cyc;
        i++;
      end
      sample(cyc);
    end
    cmd_valid = 1'b0;
    last = cyc;
    check("all_pushed", last, 8'(i), 8'(NCMD));

    // Schedule: pop one edge after the push or after the previous done.
    prev = 0;
    for (int k = 0; k < NCMD; k++) begin
      pop_t[k] = (push_t[k] + 1 > prev + 1) ? push_t[k] + 1 : prev + 1;
      lat = (c_op[k] == 2'b00) ? 1 : (c_op[k] == 2'b11) ? 2 * H + 1 : H + 1;
      done_t[k] = pop_t[k] + lat;
      prev = done_t[k];
    end
    check("drained", last, 8'(done_t[NCMD-1] <= last), 8'd1);
    if (pop_t[0] < MAXC)
      check("t2_bus_at_pop", pop_t[0], o_vec[pop_t[0]], 8'hB5);

    for (int t = 0; t <= last; t++) begin
      occ = 0; occ_p = 0; cmp_n = 0; wr_n = 0; vec_e = 6'd0;
      done_e = 1'b0; nonidle_p = 1'b0;
      for (int k = 0; k < NCMD; k++) begin
        if (push_t[k] <= t)     occ++;
        if (pop_t[k] <= t)      occ--;
        if (push_t[k] <= t - 1) occ_p++;
        if (pop_t[k] <= t - 1)  occ_p--;
        if ((c_op[k] == 2'b01 || c_op[k] == 2'b11) && pop_t[k] <= t) begin
          cmp_n++;
          vec_e = c_vec[k];
        end
        wr_time = (c_op[k] == 2'b10) ? pop_t[k] :
                  (c_op[k] == 2'b11) ? pop_t[k] + H : -1;
        if (wr_time >= 0 && wr_time <= t) wr_n++;
        if (done_t[k] == t) done_e = 1'b1;
        if (pop_t[k] <= t - 1 && t - 1 < done_t[k]) nonidle_p = 1'b1;
      end
      busy_e = (t > 0) && (nonidle_p || occ_p > 0);
      check("vector_out", t, o_vec[t], {vec_e, wr_n[0], cmp_n[0]});
      check("row_idx", t, 8'(o_row[t]), 8'(wr_n % NR));
      check("done", t, 8'(o_done[t]), 8'(done_e));
      check("busy", t, 8'(o_busy[t]), 8'(busy_e));
      check("cmd_ready", t, 8'(o_rdy[t]), 8'(occ < DEPTH));
    end

    // Reset in the middle of a LOAD_ROW with more commands queued behind it.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_vec = 6'h15;
    @(posedge clk); #1;
    cmd_op = 2'b01; cmd_vec = 6'h02;
    @(posedge clk); #1;
    cmd_vec = 6'h03;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("midload_busy", 0, 8'(busy), 8'd1);
    check("midload_vec", 0, 8'(vector_out[7:2]), 8'h15);
    #2 rst = 1'b1;
    #1;
    check("rst_vec", 0, vector_out, 8'h00);
    check("rst_ready", 0, 8'(cmd_ready), 8'd1);
    check("rst_busy", 0, 8'(busy), 8'd0);
    check("rst_done", 0, 8'(done), 8'd0);
    check("rst_row", 0, 8'(row_idx), 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      check("flush_busy", t, 8'(busy), 8'd0);
      check("flush_done", t, 8'(done), 8'd0);
      check("flush_vec", t, vector_out, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
